// File: rtl/p2_master_if.sv
// P2 bus signal bundle between the CPU-side initiator (master) and the
// memory/IO slaves. wait_n is the wired-OR stretch request from all slaves.
interface p2_master_if;
    logic [22:0] addr;
    logic        ras_n;
    logic        cas_n;
    logic        go_n;
    logic        rw_n;
    logic        wel_n;
    logic        weu_n;
    logic        wait_n;
    logic [15:0] datao;
    logic [15:0] datai;

    modport master (
        output addr, ras_n, cas_n, go_n, rw_n, wel_n, weu_n, datao,
        input  wait_n, datai
    );

    modport slave (
        input  addr, ras_n, cas_n, go_n, rw_n, wel_n, weu_n, datao,
        output wait_n, datai
    );
endinterface

// File: rtl/p2_master.sv
// CPU-side initiator for the P2 bus. Takes one request from the CPU and runs
// one bus cycle (ADDR -> STROBE -> DONE -> RECOVER). The cycle is stretched
// while a slave pulls wait_n low. A cycle that is still waiting after TIMEOUT
// strobe cycles is aborted with cpu_err. All outputs come straight from flops.
module p2_master #(
    parameter int ADDR_SETUP = 1,
    parameter int MIN_STROBE = 2,
    parameter int RECOVERY   = 1,
    parameter int TIMEOUT    = 255,
    parameter int TO_W       = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req_i,
    input  logic [22:0] cpu_addr_i,
    input  logic        cpu_rw_n_i,
    input  logic [1:0]  cpu_be_i,
    input  logic [15:0] cpu_wdata_i,
    output logic [15:0] cpu_rdata_o,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,
    p2_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_DONE    = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    // Terminal counts for the shared phase counter.
    localparam logic [TO_W-1:0] CNT_ONE    = TO_W'(1);
    localparam logic [TO_W-1:0] SETUP_LAST = TO_W'(ADDR_SETUP - 1);
    localparam logic [TO_W-1:0] MIN_LAST   = TO_W'(MIN_STROBE - 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT     = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] REC_LAST   = TO_W'((RECOVERY > 0) ? (RECOVERY - 1) : 0);

    // Strobe vector order: {ras_n, cas_n, go_n, rw_n, wel_n, weu_n}.
    localparam logic [5:0] STRB_IDLE = 6'b111111;

    state_t          state_q;
    logic [TO_W-1:0] cnt_q;
    logic [22:0]     addr_q;
    logic [15:0]     datao_q;
    logic            rw_q;
    logic [1:0]      be_q;
    logic [5:0]      strb_q;
    logic [15:0]     rdata_q;
    logic            ack_q;
    logic            err_q;
    logic            accept_s;

    // A new request is taken in IDLE, or on the edge that ends recovery so
    // back-to-back requests see exactly RECOVERY idle cycles after DONE.
    always_comb begin
        accept_s = 1'b0;
        if (state_q == ST_IDLE) begin
            accept_s = cpu_req_i;
        end else if ((state_q == ST_RECOVER) && (cnt_q == REC_LAST)) begin
            accept_s = cpu_req_i;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Bus-cycle sequencer: state, phase counter, latched request and all outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= 23'd0;
            datao_q <= 16'd0;
            rw_q    <= 1'b1;
            be_q    <= 2'b00;
            strb_q  <= STRB_IDLE;
            rdata_q <= 16'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Completion flags are single-cycle pulses.
            ack_q <= 1'b0;
            err_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                end

                ST_ADDR: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= ST_STROBE;
                        cnt_q   <= '0;
                        strb_q  <= {1'b0, 1'b0, 1'b0, rw_q,
                                    rw_q | ~be_q[0], rw_q | ~be_q[1]};
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_STROBE: begin
                    if ((cnt_q >= MIN_LAST) && bus.wait_n) begin
                        // Slaves released: finish, capture read data.
                        state_q <= ST_DONE;
                        strb_q  <= STRB_IDLE;
                        ack_q   <= 1'b1;
                        if (rw_q) begin
                            rdata_q <= bus.datai;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end else if ((cnt_q == TO_LAST) && !bus.wait_n) begin
                        // Slave never released: abort with error.
                        state_q <= ST_DONE;
                        strb_q  <= STRB_IDLE;
                        err_q   <= 1'b1;
                        rdata_q <= 16'hFFFF;
                    end else if (cnt_q == TO_SAT) begin
                        cnt_q <= cnt_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_DONE: begin
                    cnt_q  <= '0;
                    strb_q <= STRB_IDLE;
                    if (RECOVERY > 0) begin
                        state_q <= ST_RECOVER;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                ST_RECOVER: begin
                    if (cnt_q == REC_LAST) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    strb_q  <= STRB_IDLE;
                end
            endcase

            // Taking a request overrides the IDLE/RECOVER bookkeeping above.
            if (accept_s) begin
                state_q <= ST_ADDR;
                cnt_q   <= '0;
                addr_q  <= cpu_addr_i;
                datao_q <= cpu_wdata_i;
                rw_q    <= cpu_rw_n_i;
                be_q    <= cpu_be_i;
                strb_q  <= {1'b0, 1'b1, 1'b1, cpu_rw_n_i, 1'b1, 1'b1};
            end
        end
    end

    assign bus.addr     = addr_q;
    assign bus.datao    = datao_q;
    assign bus.ras_n    = strb_q[5];
    assign bus.cas_n    = strb_q[4];
    assign bus.go_n     = strb_q[3];
    assign bus.rw_n     = strb_q[2];
    assign bus.wel_n    = strb_q[1];
    assign bus.weu_n    = strb_q[0];
    assign cpu_rdata_o  = rdata_q;
    assign cpu_ack_o    = ack_q;
    assign cpu_err_o    = err_q;

endmodule

// File: tb/tb_p2_master.sv
// Bench for p2_master: directed P2 cycles plus a randomized stream, each
// checked cycle by cycle against a transaction-level expectation of the
// bus phases (address setup, strobe length from the wait pattern, done).
module tb_p2_master;
    localparam int ADDR_SETUP = 1;
    localparam int MIN_STROBE = 2;
    localparam int RECOVERY   = 1;
    localparam int TIMEOUT    = 16;
    localparam int TO_W       = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0;
    logic [22:0] cpu_addr = 23'd0;
    logic        cpu_rw_n = 1'b1;
    logic [1:0]  cpu_be = 2'b00;
    logic [15:0] cpu_wdata = 16'd0;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_err;

    p2_master_if bus();

    p2_master #(
        .ADDR_SETUP(ADDR_SETUP), .MIN_STROBE(MIN_STROBE), .RECOVERY(RECOVERY),
        .TIMEOUT(TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_rw_n_i(cpu_rw_n),
        .cpu_be_i(cpu_be), .cpu_wdata_i(cpu_wdata),
        .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [22:0] last_addr = 23'd0;
    logic [15:0] last_wd = 16'd0;
    logic [15:0] exp_rd = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobes {ras,cas,go,rw,wel,weu} plus the two completion flags.
    task automatic chk_cyc(input string tag, input logic [5:0] strb, input logic ack, input logic err);
        chk({tag, "_strb"}, 32'({bus.ras_n, bus.cas_n, bus.go_n, bus.rw_n, bus.wel_n, bus.weu_n}), 32'(strb));
        chk({tag, "_ack"}, 32'(cpu_ack), 32'(ack));
        chk({tag, "_err"}, 32'(cpu_err), 32'(err));
    endtask

    task automatic chk_hold(input string tag, input logic [22:0] a, input logic [15:0] wd);
        chk({tag, "_addr"}, 32'(bus.addr), 32'(a));
        chk({tag, "_datao"}, 32'(bus.datao), 32'(wd));
    endtask

    // Called in a DONE cycle: drop the request and sit through recovery and idle.
    task automatic idle_gap();
        cpu_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wait_n = 1'($urandom);
            bus.datai  = 16'($urandom);
            tick();
            chk_cyc("gap", 6'h3F, 1'b0, 1'b0);
            chk_hold("gap", last_addr, last_wd);
        end
    endtask

    // One bus transaction. b2b=1 means we are in the previous DONE cycle with
    // no gap. nlow: strobe cycles with wait_n low before release (unless rnd_wait).
    task automatic run_txn(input bit b2b, input logic [22:0] a, input logic rw,
                           input logic [1:0] be, input logic [15:0] wd, input int nlow,
                           input bit rnd_wait, input bit drop, input bit fix_di,
                           input logic [15:0] di);
        bit          w [TIMEOUT];
        int          n;
        bit          to_err;
        logic [15:0] last_di;
        logic [5:0]  s_addr;
        logic [5:0]  s_strb;

        for (int k = 0; k < TIMEOUT; k++)
            w[k] = rnd_wait ? 1'($urandom_range(0, 1)) : (k >= nlow);
        // Strobe length: first released cycle at or after the minimum, else timeout.
        n = 0;
        for (int k = MIN_STROBE - 1; k < TIMEOUT; k++)
            if (w[k] && n == 0) n = k + 1;
        to_err = (n == 0);
        if (to_err) n = TIMEOUT;

        s_addr  = {1'b0, 1'b1, 1'b1, rw, 1'b1, 1'b1};
        s_strb  = {3'b000, rw, rw | ~be[0], rw | ~be[1]};
        last_di = 16'd0;

        cpu_req = 1'b1; cpu_addr = a; cpu_rw_n = rw; cpu_be = be; cpu_wdata = wd;
        bus.wait_n = 1'($urandom);
        bus.datai  = 16'($urandom);
        if (b2b) begin
            tick();
            chk_cyc("recover", 6'h3F, 1'b0, 1'b0);
        end
        tick();
        for (int j = 0; j < ADDR_SETUP; j++) begin
            chk_cyc("addr", s_addr, 1'b0, 1'b0);
            chk_hold("addr", a, wd);
            cpu_addr = 23'($urandom); cpu_wdata = 16'($urandom);
            cpu_rw_n = 1'($urandom); cpu_be = 2'($urandom);
            if (drop) cpu_req = 1'b0;
            bus.wait_n = 1'($urandom);
            bus.datai  = 16'($urandom);
            tick();
        end
        for (int k = 0; k < n; k++) begin
            chk_cyc("strobe", s_strb, 1'b0, 1'b0);
            chk_hold("strobe", a, wd);
            bus.wait_n = w[k];
            bus.datai  = fix_di ? di : 16'($urandom);
            last_di    = bus.datai;
            tick();
        end
        if (to_err) exp_rd = 16'hFFFF;
        else if (rw) exp_rd = last_di;
        chk_cyc("done", 6'h3F, ~to_err, to_err);
        chk("done_rdata", 32'(cpu_rdata), 32'(exp_rd));
        chk_hold("done", a, wd);
        last_addr = a;
        last_wd   = wd;
    endtask

    initial begin
        logic [22:0] base [4];
        bit b2b;
        base[0] = 23'h000000; base[1] = 23'h700000; base[2] = 23'h780000; base[3] = 23'h781000;
        bus.wait_n = 1'b1;
        bus.datai  = 16'd0;

        // Reset state.
        tick(); tick();
        chk_cyc("rst", 6'h3F, 1'b0, 1'b0);
        chk_hold("rst", 23'd0, 16'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        reset_n = 1'b1;
        tick();
        chk_cyc("rst_idle", 6'h3F, 1'b0, 1'b0);

        // Plain read, ack four cycles after the request edge.
        run_txn(1'b0, 23'h000010, 1'b1, 2'b11, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 16'hA5C3);
        chk("t1_rdata", 32'(cpu_rdata), 32'h0000A5C3);
        idle_gap();
        // Upper-byte write.
        run_txn(1'b0, 23'h700000, 1'b0, 2'b10, 16'h1234, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        idle_gap();
        // Five wait cycles: six strobe cycles.
        run_txn(1'b0, 23'h781000, 1'b1, 2'b00, 16'h0000, 5, 1'b0, 1'b1, 1'b0, 16'h0);
        idle_gap();
        // Stuck wait: timeout error.
        run_txn(1'b0, 23'h780000, 1'b1, 2'b11, 16'h0000, 1000, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("t4_rdata", 32'(cpu_rdata), 32'h0000FFFF);
        idle_gap();
        // Write with no byte enables, then a back-to-back read.
        run_txn(1'b0, 23'h000123, 1'b0, 2'b00, 16'hBEEF, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        run_txn(1'b1, 23'h000124, 1'b1, 2'b11, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0);
        idle_gap();

        // Reset in the middle of a strobe phase.
        cpu_req = 1'b1; cpu_addr = 23'h0000AA; cpu_rw_n = 1'b1; cpu_be = 2'b11; cpu_wdata = 16'h5555;
        tick();
        cpu_req = 1'b0;
        tick();
        chk_cyc("pre_rst", {3'b000, 1'b1, 1'b1, 1'b1}, 1'b0, 1'b0);
        bus.wait_n = 1'b1;
        reset_n = 1'b0;
        tick();
        chk_cyc("mid_rst", 6'h3F, 1'b0, 1'b0);
        chk_hold("mid_rst", 23'd0, 16'd0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'd0);
        reset_n = 1'b1;
        exp_rd = 16'd0; last_addr = 23'd0; last_wd = 16'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cyc("post_rst", 6'h3F, 1'b0, 1'b0);
        end

        // Randomized stream.
        for (int i = 0; i < 40; i++) begin
            b2b = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (!b2b) idle_gap();
            run_txn(b2b, base[$urandom_range(0, 3)] + 23'($urandom_range(0, 255)),
                    1'($urandom), 2'($urandom), 16'($urandom), 0, 1'b1,
                    1'($urandom), 1'b0, 16'h0);
        end
        idle_gap();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
